i2c_lm75a_slave: RTL and testbench

- I2C responder that emulates an LM75A temperature sensor on a two-wire bus so the existing I2C temperature-read master can be exercised in simulation and on-board loopback.
- Samples SCL/SDA with the 50 MHz system clock, detects START/STOP, matches a 7-bit address, and returns a 16-bit temperature word MSB-first.
- Also accepts and ACKs write transactions (the pointer byte and any following bytes) without acting on the data, beyond reporting a pointer-write event.
- SDA is open-drain: the block drives 0 or releases to Z, never drives 1.

---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_lm75a_slave_if.sv | 28 ++
 rtl/i2c_line_sync.sv | 30 +++
 rtl/i2c_lm75a_slave.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_lm75a_slave.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared constants for the LM75A-emulating I2C responder: one-hot state
// encoding, the LM75A bus address, R/W bit values and a bit-counter helper.
package i2c_pkg;

    localparam logic [8:0] S_IDLE     = 9'b000000001;
    localparam logic [8:0] S_ADDR     = 9'b000000010;
    localparam logic [8:0] S_ADDR_ACK = 9'b000000100;
    localparam logic [8:0] S_TX       = 9'b000001000;
    localparam logic [8:0] S_TX_ACK   = 9'b000010000;
    localparam logic [8:0] S_TX_NEXT  = 9'b000100000;
    localparam logic [8:0] S_RX       = 9'b001000000;
    localparam logic [8:0] S_RX_ACK   = 9'b010000000;
    localparam logic [8:0] S_IGNORE   = 9'b100000000;

    localparam logic [6:0] LM75A_ADDR = 7'b1001000;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Bit counter never wraps: it parks at 8 until a byte boundary clears it.
    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        logic [3:0] res;
        if (cnt >= 4'd8) begin
            res = 4'd8;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/i2c_lm75a_slave_if.sv
// Bus bundle between the LM75A responder and its host side: SCL input,
// temperature word and the status/pointer outputs.
interface i2c_lm75a_slave_if;
    logic        scl;
    logic [15:0] temp_in;
    logic        busy;
    logic        rd_done;
    logic        wr_ptr_valid;
    logic [7:0]  wr_ptr;

    modport slave (
        input  scl,
        input  temp_in,
        output busy,
        output rd_done,
        output wr_ptr_valid,
        output wr_ptr
    );

    modport master (
        output scl,
        output temp_in,
        input  busy,
        input  rd_done,
        input  wr_ptr_valid,
        input  wr_ptr
    );
endinterface

// File: rtl/i2c_line_sync.sv
// Multi-flop synchronizer for one I2C line with a history flop providing
// the conditioned level and single-clk rise/fall strobes.
module i2c_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Shift the raw line through the synchronizer; reset to the idle-high bus level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{1'b1}};
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], line_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[STAGES-1] & hist_q;
endmodule

// File: rtl/i2c_lm75a_slave.sv
// LM75A temperature-sensor emulation on an open-drain I2C bus: serves a
// coherent 16-bit word on reads and ACKs writes, reporting the pointer byte.
module i2c_lm75a_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = LM75A_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    inout  wire                sda,
    i2c_lm75a_slave_if.slave   bus
);
    logic scl_lvl_s, scl_rise_s, scl_fall_s;
    logic sda_lvl_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;
    logic [7:0] next_byte_s;

    logic [8:0]  state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [15:0] tx_shadow_q, tx_shadow_d;
    logic        byte_sel_q, byte_sel_d;
    logic        first_byte_q, first_byte_d;
    logic        sda_low_q, sda_low_d;
    logic        busy_q, busy_d;
    logic        rd_done_q, rd_done_d;
    logic        wr_ptr_valid_q, wr_ptr_valid_d;
    logic [7:0]  wr_ptr_q, wr_ptr_d;

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .rst(rst), .line_i(bus.scl),
        .level_o(scl_lvl_s), .rise_o(scl_rise_s), .fall_o(scl_fall_s)
    );

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .rst(rst), .line_i(sda),
        .level_o(sda_lvl_s), .rise_o(sda_rise_s), .fall_o(sda_fall_s)
    );

    assign start_s     = sda_fall_s & scl_lvl_s;
    assign stop_s      = sda_rise_s & scl_lvl_s;
    assign next_byte_s = byte_sel_q ? tx_shadow_q[7:0] : tx_shadow_q[15:8];

    // Protocol FSM: STOP beats START, which beats any per-state bit activity.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        tx_shift_d     = tx_shift_q;
        tx_shadow_d    = tx_shadow_q;
        byte_sel_d     = byte_sel_q;
        first_byte_d   = first_byte_q;
        sda_low_d      = sda_low_q;
        busy_d         = busy_q;
        rd_done_d      = 1'b0;
        wr_ptr_valid_d = 1'b0;
        wr_ptr_d       = wr_ptr_q;
        if (stop_s) begin
            state_d   = S_IDLE;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 4'd0;
        end else if (start_s) begin
            state_d   = S_ADDR;
            sda_low_d = 1'b0;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sda_low_d = 1'b0;
                end
                S_ADDR: begin
                    if (scl_rise_s) begin
                        shift_d   = {shift_q[6:0], sda_lvl_s};
                        bit_cnt_d = sat_inc(bit_cnt_q);
                    end else if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[7:1] == DEVICE_ADDR) begin
                            sda_low_d   = 1'b1;
                            tx_shadow_d = bus.temp_in;
                            busy_d      = 1'b1;
                            state_d     = S_ADDR_ACK;
                        end else begin
                            sda_low_d = 1'b0;
                            busy_d    = 1'b0;
                            state_d   = S_IGNORE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall_s) begin
                        bit_cnt_d = 4'd0;
                        case (shift_q[0])
                            RW_READ: begin
                                tx_shift_d = tx_shadow_q[15:8];
                                sda_low_d  = ~tx_shadow_q[15];
                                byte_sel_d = 1'b0;
                                state_d    = S_TX;
                            end
                            RW_WRITE: begin
                                sda_low_d    = 1'b0;
                                first_byte_d = 1'b1;
                                state_d      = S_RX;
                            end
                            default: begin
                                sda_low_d = 1'b0;
                                state_d   = S_IGNORE;
                            end
                        endcase
                    end else begin
                        state_d = S_ADDR_ACK;
                    end
                end
                S_TX: begin
                    if (scl_fall_s) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_low_d = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = S_TX_ACK;
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                            sda_low_d  = ~tx_shift_q[6];
                            bit_cnt_d  = sat_inc(bit_cnt_q);
                        end
                    end else begin
                        state_d = S_TX;
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise_s) begin
                        if (!sda_lvl_s) begin
                            byte_sel_d = ~byte_sel_q;
                            state_d    = S_TX_NEXT;
                        end else begin
                            rd_done_d = 1'b1;
                            state_d   = S_IGNORE;
                        end
                    end else begin
                        state_d = S_TX_ACK;
                    end
                end
                S_TX_NEXT: begin
                    if (scl_fall_s) begin
                        tx_shift_d = next_byte_s;
                        sda_low_d  = ~next_byte_s[7];
                        bit_cnt_d  = 4'd0;
                        state_d    = S_TX;
                    end else begin
                        state_d = S_TX_NEXT;
                    end
                end
                S_RX: begin
                    if (scl_rise_s) begin
                        shift_d   = {shift_q[6:0], sda_lvl_s};
                        bit_cnt_d = sat_inc(bit_cnt_q);
                    end else if (scl_fall_s && (bit_cnt_q == 4'd8)) begin
                        sda_low_d = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = S_RX_ACK;
                        if (first_byte_q) begin
                            wr_ptr_d       = shift_q;
                            wr_ptr_valid_d = 1'b1;
                            first_byte_d   = 1'b0;
                        end else begin
                            wr_ptr_d = wr_ptr_q;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                S_RX_ACK: begin
                    if (scl_fall_s) begin
                        sda_low_d = 1'b0;
                        state_d   = S_RX;
                    end else begin
                        state_d = S_RX_ACK;
                    end
                end
                S_IGNORE: begin
                    sda_low_d = 1'b0;
                end
                default: begin
                    state_d   = S_IDLE;
                    sda_low_d = 1'b0;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset releases SDA on the edge it is sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            bit_cnt_q      <= 4'd0;
            shift_q        <= 8'h00;
            tx_shift_q     <= 8'h00;
            tx_shadow_q    <= 16'h0000;
            byte_sel_q     <= 1'b0;
            first_byte_q   <= 1'b0;
            sda_low_q      <= 1'b0;
            busy_q         <= 1'b0;
            rd_done_q      <= 1'b0;
            wr_ptr_valid_q <= 1'b0;
            wr_ptr_q       <= 8'h00;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            tx_shift_q     <= tx_shift_d;
            tx_shadow_q    <= tx_shadow_d;
            byte_sel_q     <= byte_sel_d;
            first_byte_q   <= first_byte_d;
            sda_low_q      <= sda_low_d;
            busy_q         <= busy_d;
            rd_done_q      <= rd_done_d;
            wr_ptr_valid_q <= wr_ptr_valid_d;
            wr_ptr_q       <= wr_ptr_d;
        end
    end

    assign sda              = sda_low_q ? 1'b0 : 1'bz;
    assign bus.busy         = busy_q;
    assign bus.rd_done      = rd_done_q;
    assign bus.wr_ptr_valid = wr_ptr_valid_q;
    assign bus.wr_ptr       = wr_ptr_q;
endmodule

// File: tb/tb_i2c_lm75a_slave.sv
// Directed I2C-master bench for the LM75A responder: reads, writes, address
// mismatch, mid-read temperature change, byte wrap and mid-transfer reset.
module tb_i2c_lm75a_slave;
    localparam int Q = 20;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic m_sda_low = 1'b0;
    wire  sda;

    int n_checks      = 0;
    int n_fail        = 0;
    int rd_cnt        = 0;
    int wp_cnt        = 0;
    int busy_cnt      = 0;
    int slave_low_cnt = 0;

    i2c_lm75a_slave_if bus();

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_lm75a_slave #(.DEVICE_ADDR(7'b1001000), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .rst(rst),
        .sda(sda),
        .bus(bus)
    );

    always #10 clk = ~clk;

    // Event counters sampled on the active edge; the master only moves on negedge.
    always @(posedge clk) begin
        if (bus.rd_done) rd_cnt <= rd_cnt + 1;
        if (bus.wr_ptr_valid) wp_cnt <= wp_cnt + 1;
        if (bus.busy) busy_cnt <= busy_cnt + 1;
        if ((sda == 1'b0) && !m_sda_low) slave_low_cnt <= slave_low_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0;
        wait_q();
        bus.scl = 1'b1;
        wait_q();
        m_sda_low = 1'b1;
        wait_q();
        bus.scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1;
        wait_q();
        bus.scl = 1'b1;
        wait_q();
        m_sda_low = 1'b0;
        wait_q();
        wait_q();
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = ~b;
        wait_q();
        bus.scl = 1'b1;
        wait_q();
        wait_q();
        bus.scl = 1'b0;
        wait_q();
    endtask

    task automatic recv_bit(output logic b);
        m_sda_low = 1'b0;
        wait_q();
        bus.scl = 1'b1;
        wait_q();
        b = sda;
        wait_q();
        bus.scl = 1'b0;
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack_n);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack_n);
    endtask

    task automatic recv_byte(input logic do_ack, output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            d = {d[6:0], b};
        end
        send_bit(~do_ack);
    endtask

    initial begin
        logic       ack_n;
        logic       b;
        logic [7:0] d;
        int         r0;
        int         w0;
        int         s0;
        int         b0;

        bus.scl     = 1'b1;
        bus.temp_in = 16'h1980;
        repeat (5) @(negedge clk);
        check_eq("reset_sda", {31'd0, sda}, 32'd1);
        check_eq("reset_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("reset_rd_done", {31'd0, bus.rd_done}, 32'd0);
        check_eq("reset_wr_ptr_valid", {31'd0, bus.wr_ptr_valid}, 32'd0);
        check_eq("reset_wr_ptr", {24'd0, bus.wr_ptr}, 32'h00);
        rst = 1'b0;
        wait_q();

        // Basic read of 0x1980 with NACK on the LSB byte
        r0 = rd_cnt;
        i2c_start();
        send_byte(8'h91, ack_n);
        check_eq("rd_addr_ack", {31'd0, ack_n}, 32'd0);
        check_eq("rd_busy_high", {31'd0, bus.busy}, 32'd1);
        recv_byte(1'b1, d);
        check_eq("rd_msb", {24'd0, d}, 32'h19);
        recv_byte(1'b0, d);
        check_eq("rd_lsb", {24'd0, d}, 32'h80);
        check_eq("rd_done_once", r0 - r0 + (rd_cnt - r0), 32'd1);
        check_eq("rd_busy_before_stop", {31'd0, bus.busy}, 32'd1);
        i2c_stop();
        check_eq("rd_busy_after_stop", {31'd0, bus.busy}, 32'd0);

        // Foreign address: slave must stay off the bus
        s0 = slave_low_cnt;
        b0 = busy_cnt;
        i2c_start();
        send_byte(8'h93, ack_n);
        check_eq("bad_addr_nack", {31'd0, ack_n}, 32'd1);
        recv_byte(1'b0, d);
        check_eq("bad_addr_data", {24'd0, d}, 32'hFF);
        i2c_stop();
        check_eq("bad_addr_no_drive", slave_low_cnt - s0, 32'd0);
        check_eq("bad_addr_no_busy", busy_cnt - b0, 32'd0);

        // temp_in change between bytes must not tear the word
        bus.temp_in = 16'h1980;
        i2c_start();
        send_byte(8'h91, ack_n);
        check_eq("coh_addr_ack", {31'd0, ack_n}, 32'd0);
        recv_byte(1'b1, d);
        check_eq("coh_msb", {24'd0, d}, 32'h19);
        bus.temp_in = 16'h7FFF;
        recv_byte(1'b0, d);
        check_eq("coh_lsb", {24'd0, d}, 32'h80);
        i2c_stop();

        // Write: pointer byte then one data byte
        w0 = wp_cnt;
        r0 = rd_cnt;
        i2c_start();
        send_byte(8'h90, ack_n);
        check_eq("wr_addr_ack", {31'd0, ack_n}, 32'd0);
        send_byte(8'h03, ack_n);
        check_eq("wr_ptr_ack", {31'd0, ack_n}, 32'd0);
        send_byte(8'hAA, ack_n);
        check_eq("wr_data_ack", {31'd0, ack_n}, 32'd0);
        i2c_stop();
        check_eq("wr_ptr_valid_once", wp_cnt - w0, 32'd1);
        check_eq("wr_ptr_value", {24'd0, bus.wr_ptr}, 32'h03);
        check_eq("wr_no_rd_done", rd_cnt - r0, 32'd0);

        // Three-byte read wraps back to the MSB
        bus.temp_in = 16'h1234;
        i2c_start();
        send_byte(8'h91, ack_n);
        check_eq("wrap_addr_ack", {31'd0, ack_n}, 32'd0);
        recv_byte(1'b1, d);
        check_eq("wrap_b0", {24'd0, d}, 32'h12);
        recv_byte(1'b1, d);
        check_eq("wrap_b1", {24'd0, d}, 32'h34);
        recv_byte(1'b0, d);
        check_eq("wrap_b2", {24'd0, d}, 32'h12);
        i2c_stop();

        // Reset while the slave holds SDA low inside the MSB byte
        bus.temp_in = 16'h0080;
        i2c_start();
        send_byte(8'h91, ack_n);
        check_eq("rst_addr_ack", {31'd0, ack_n}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            recv_bit(b);
            check_eq("rst_pre_bits", {31'd0, b}, 32'd0);
        end
        check_eq("rst_slave_drives", {31'd0, sda}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_sda_released", {31'd0, sda}, 32'd1);
        repeat (3) @(negedge clk);
        check_eq("rst_busy_cleared", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        wait_q();
        i2c_stop();

        bus.temp_in = 16'h1980;
        i2c_start();
        send_byte(8'h91, ack_n);
        check_eq("post_rst_addr_ack", {31'd0, ack_n}, 32'd0);
        recv_byte(1'b1, d);
        check_eq("post_rst_msb", {24'd0, d}, 32'h19);
        recv_byte(1'b0, d);
        check_eq("post_rst_lsb", {24'd0, d}, 32'h80);
        i2c_stop();
        check_eq("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
